// File: rtl/f_fetch_stage_if.sv
// Fetch-stage bundle: next-PC controls from D/CP0, the instruction-memory port and the F/D outputs.
// The master modport is the fetch stage; the slave modport is its surrounding pipeline and memory.
interface f_fetch_stage_if;
    logic        req;
    logic        stall;
    logic        eret_d;
    logic [31:0] epc;
    logic [1:0]  npc_sel;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic        d_is_bj;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [4:0]  exccode_f;
    logic        isdelay_f;

    modport master (
        input  req, stall, eret_d, epc, npc_sel,
        input  br_target, j_target, jr_target, d_is_bj, i_rdata,
        output i_addr, instr_f, pc_f, pc_plus4_f, exccode_f, isdelay_f
    );

    modport slave (
        output req, stall, eret_d, epc, npc_sel,
        output br_target, j_target, jr_target, d_is_bj, i_rdata,
        input  i_addr, instr_f, pc_f, pc_plus4_f, exccode_f, isdelay_f
    );
endinterface

// File: rtl/f_fetch_stage.sv
// MIPS fetch stage: owns the PC and selects next PC (reset > req > stall > eret > npc_sel); AdEL check under FETCH_ADEL_CHECK_EN.
// Latency: outputs are combinational from the PC register and i_rdata; the PC updates on each rising clk edge.
// Backpressure: stall holds the PC, but an exception-entry req always redirects.
module f_fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO   = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI   = 32'h0000_6FFC
) (
    input  logic           clk,
    input  logic           reset,
    f_fetch_stage_if.master fif
);

    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic        squash;
    logic        adel;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_nxt = pc_plus4;
        if (fif.req) begin
            pc_nxt = EXC_ENTRY;
        end else if (fif.stall) begin
            pc_nxt = pc_q;
        end else if (fif.eret_d) begin
            pc_nxt = fif.epc;
        end else begin
            case (fif.npc_sel)
                2'd1:    pc_nxt = fif.br_target;
                2'd2:    pc_nxt = fif.j_target;
                2'd3:    pc_nxt = fif.jr_target;
                default: pc_nxt = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_nxt;
        end
    end

    // eret has no delay slot: the word behind it is dropped only once it actually redirects.
    assign squash = fif.eret_d & ~fif.req & ~fif.stall;

`ifdef FETCH_ADEL_CHECK_EN
    assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI);
`else
    logic [63:0] unused_range;
    assign unused_range = {IMEM_LO, IMEM_HI};
    assign adel         = 1'b0;
`endif

    assign fif.i_addr     = pc_q;
    assign fif.pc_f       = pc_q;
    assign fif.pc_plus4_f = pc_plus4;
    assign fif.instr_f    = (squash || adel) ? 32'd0 : fif.i_rdata;
    assign fif.exccode_f  = (!squash && adel) ? 5'd4 : 5'd0;
    assign fif.isdelay_f  = squash ? 1'b0 : fif.d_is_bj;

endmodule

// File: doc/f_fetch_stage.md
# f_fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline with precise exceptions. It owns the program counter and selects the next PC from sequential, branch, jump, exception-entry and `eret` sources. It drives the instruction-memory address and presents instruction, PC, PC+4, fetch exception code and delay-slot flag to the F/D pipeline register directly downstream.

## Interface

Parameters:
- `PC_RESET`, 32'h0000_3000, PC value after reset.
- `EXC_ENTRY`, 32'h0000_4180, handler address loaded on `req`.
- `IMEM_LO`, 32'h0000_3000, lowest legal fetch address.
- `IMEM_HI`, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  1  exception/interrupt entry request from CP0.
- `stall`  in  1  hazard-unit stall; holds the PC.
- `eret_d`  in  1  `eret` decoded in D.
- `epc`  in  32  return address from CP0.
- `npc_sel`  in  2  next-PC select from D: 0 sequential, 1 branch taken, 2 jump immediate, 3 jump register.
- `br_target`  in  32  branch target.
- `j_target`  in  32  j/jal target.
- `jr_target`  in  32  jr/jalr target, forwarded.
- `d_is_bj`  in  1  D holds a branch or jump.
- `i_addr`  out  32  instruction-memory address; equals PC.
- `i_rdata`  in  32  instruction word; combinational read of `i_addr`.
- `instr_f`  out  32  instruction to F/D.
- `pc_f`  out  32  PC to F/D.
- `pc_plus4_f`  out  32  PC+4 to F/D.
- `exccode_f`  out  5  fetch exception code; 0 = none, 4 = AdEL.
- `isdelay_f`  out  1  fetched instruction is in a delay slot.

## Operation

- Single 32-bit PC register is the only architectural state.
- Next-PC priority, highest first:
  - `reset` loads `PC_RESET`.
  - `req` loads `EXC_ENTRY`, regardless of `stall`, `eret_d` or `npc_sel`.
  - `stall` holds the PC.
  - `eret_d` loads `epc`.
  - Otherwise `npc_sel` applies: 0 gives PC+4, 1 `br_target`, 2 `j_target`, 3 `jr_target`.
- `eret` has no delay slot. When `eret_d` is high and neither `req` nor `stall` is high, the word fetched this cycle is squashed: `instr_f`=0, `exccode_f`=0, `isdelay_f`=0. `pc_f` is unchanged.
- `isdelay_f` = `d_is_bj`, except under an `eret` squash.
- AdEL fetch check (see Configuration): PC[1:0]≠0, or PC<`IMEM_LO`, or PC>`IMEM_HI`.
  - Result: `exccode_f`=4 and `instr_f`=0. `pc_f` keeps the faulting PC for EPC.
  - An AdEL does not alter next-PC selection. CP0 raises `req` when the fault reaches M.
- PC+4 wraps modulo 2^32 with no flag.

## Timing

- The PC changes only on the rising edge of `clk`.
- All outputs are combinational from the PC, `i_rdata` and the current inputs. There is zero-cycle latency from the PC to `instr_f`.
- Reset values (cycle after `reset` is sampled):
  - PC, `i_addr`, `pc_f` = 0x3000.
  - `pc_plus4_f` = 0x3004.
  - `exccode_f` = 0.
  - `isdelay_f` follows `d_is_bj`.
  - `instr_f` = `i_rdata` at 0x3000.
- `reset` asserted mid-stream overrides `req` and `stall` in the same cycle.
- `req` and `stall` together: the PC still moves to 0x4180. In the same cycle the F/D register loads its bubble at 0x4180.
- `stall` and `eret_d` together: the PC holds, and `eret` redirects in the first un-stalled cycle. The outputs are not squashed while stalled.
- A branch in D with `stall` high: the PC holds. The target is applied when `stall` drops, provided `npc_sel` is still valid.

## Configuration

- `FETCH_ADEL_CHECK_EN` defined: the AdEL check is active as described.
- `FETCH_ADEL_CHECK_EN` undefined: `exccode_f` is tied to 0 and `instr_f` is always `i_rdata` (apart from the `eret` squash). Range and alignment comparators are not synthesised.

## Test plan

- Reset, then 4 unstalled cycles with `npc_sel`=0 → `pc_f` = 0x3000, 0x3004, 0x3008, 0x300C; `exccode_f`=0.
- PC=0x3010, `npc_sel`=1, `br_target`=0x3040, `d_is_bj`=1 → `isdelay_f`=1 this cycle; `pc_f`=0x3040 next cycle.
- `stall`=1 for 3 cycles at PC=0x3020 → `pc_f` stays 0x3020; `stall`=0 with `npc_sel`=0 → 0x3024.
- `eret_d`=1, `epc`=0x3100, PC=0x3200 → `instr_f`=0 and `isdelay_f`=0 this cycle; `pc_f`=0x3100 next cycle.
- `req`=1 with `stall`=1 and `eret_d`=1 → `pc_f`=0x4180 next cycle; `reset`=1 together with `req` → `pc_f`=0x3000.
- `jr_target`=0x3002, then 0x7000 (macro defined) → `exccode_f`=4 and `instr_f`=0 at each. Macro undefined → `exccode_f`=0 and `instr_f`=`i_rdata`.
